updown_mod_counter: RTL and testbench

Parametrised up/down counter with a programmable modulus and a selectable end-of-range mode: wrap, saturate or one-shot. It adds synchronous clear, parallel load and cascade/status outputs to the basic 4-bit reversible counter. It serves as the general counting primitive for timers, dividers and address generators in the design, and cascades into wider counters through tc_o.

---
 rtl/updown_mod_counter.sv | 93 +++++++++
 tb/tb_updown_mod_counter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/updown_mod_counter.sv
// updown_mod_counter: up/down counter over the range 0..mod_i with
// wrap, saturate or one-shot behaviour at the terminal value.
// Also provides synchronous clear and parallel load.
// tc_o is a combinational carry/borrow for cascading wider counters.
module updown_mod_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             ld_i,
    input  logic [WIDTH-1:0] ld_val_i,
    input  logic             ce_i,
    input  logic             ctr_i,
    input  logic [WIDTH-1:0] mod_i,
    input  logic [1:0]       mode_i,
    output logic [WIDTH-1:0] d_out,
    output logic             tc_o,
    output logic             wrap_o,
    output logic             done_o
);

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = '0;

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] term;
    logic             mode_sat;
    logic             mode_os;
    logic             halted;

    // The terminal value is the end of the range we are heading towards.
    // Mode 11 falls through to wrap because neither flag is set.
    always_comb begin
        term     = ctr_i ? mod_i : ZERO;
        mode_sat = (mode_i == 2'b01);
        mode_os  = (mode_i == 2'b10);
        halted   = done_q & mode_os;
    end

    // Next-state selection in priority order: clear, load, then an enabled step.
    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        // A finished one-shot forgets its flag as soon as it leaves one-shot mode.
        done_d = done_q & mode_os;
        if (clr_i) begin
            cnt_d  = ZERO;
            done_d = 1'b0;
        end else if (ld_i) begin
            cnt_d  = (ld_val_i > mod_i) ? mod_i : ld_val_i;
            done_d = 1'b0;
        end else if (ce_i && !halted) begin
            if (cnt_q > mod_i) begin
                // Modulus was lowered below the current value: snap to the top.
                cnt_d = mod_i;
            end else if (cnt_q != term) begin
                cnt_d = ctr_i ? (cnt_q + ONE) : (cnt_q - ONE);
            end else if (mode_os) begin
                done_d = 1'b1;
            end else if (!mode_sat) begin
                cnt_d  = ctr_i ? ZERO : mod_i;
                wrap_d = 1'b1;
            end
        end
    end

    // State registers; reset acts immediately without waiting for a clock.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= ZERO;
            wrap_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
            done_q <= done_d;
        end
    end

    // Terminal count stays high while saturated so a following stage keeps going,
    // but drops once a one-shot has finished.
    always_comb begin
        tc_o   = ce_i & (cnt_q == term) & ~halted;
        d_out  = cnt_q;
        wrap_o = wrap_q;
        done_o = done_q;
    end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed table-driven bench for updown_mod_counter (WIDTH = 8), plus
// hand-written sequences for power-on reset and mid-cycle asynchronous reset.
module tb_updown_mod_counter;

    localparam logic [1:0] MW = 2'b00;
    localparam logic [1:0] MS = 2'b01;
    localparam logic [1:0] MO = 2'b10;

    logic       clk = 1'b0;
    logic       rst, clr, ld, ce, ctr;
    logic [7:0] ld_val, mod;
    logic [1:0] mode;
    logic [7:0] d_out;
    logic       tc_o, wrap_o, done_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       clr;
        logic       ld;
        logic [7:0] ld_val;
        logic       ce;
        logic       ctr;
        logic [7:0] mod;
        logic [1:0] mode;
        logic [7:0] e_d;
        logic       e_wrap;
        logic       e_done;
        logic       e_tc;
    } vec_t;

    vec_t vq[$];

    updown_mod_counter #(.WIDTH(8)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .clr_i    (clr),
        .ld_i     (ld),
        .ld_val_i (ld_val),
        .ce_i     (ce),
        .ctr_i    (ctr),
        .mod_i    (mod),
        .mode_i   (mode),
        .d_out    (d_out),
        .tc_o     (tc_o),
        .wrap_o   (wrap_o),
        .done_o   (done_o)
    );

    always #5 clk = ~clk;

    function automatic void add(input logic c, input logic l, input logic [7:0] lv,
                                input logic e, input logic u, input logic [7:0] m,
                                input logic [1:0] md, input logic [7:0] xd,
                                input logic xw, input logic xdn, input logic xtc);
        vec_t v;
        v.clr = c; v.ld = l; v.ld_val = lv; v.ce = e; v.ctr = u; v.mod = m;
        v.mode = md; v.e_d = xd; v.e_wrap = xw; v.e_done = xdn; v.e_tc = xtc;
        vq.push_back(v);
    endfunction

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] xd, input logic xw,
                             input logic xdn, input logic xtc);
        check({tag, ".d_out"},  d_out,  xd);
        check({tag, ".wrap_o"}, {7'd0, wrap_o}, {7'd0, xw});
        check({tag, ".done_o"}, {7'd0, done_o}, {7'd0, xdn});
        check({tag, ".tc_o"},   {7'd0, tc_o},   {7'd0, xtc});
    endtask

    initial begin
        // Wrap mode, M=9, counting up from reset
        for (int k = 1; k <= 9; k++)
            add(0, 0, 0, 1, 1, 9, MW, 8'(k), 0, 0, (k == 9));
        add(0, 0, 0, 1, 1, 9, MW, 0, 1, 0, 0);
        add(0, 0, 0, 1, 1, 9, MW, 1, 0, 0, 0);
        add(0, 0, 0, 1, 1, 9, MW, 2, 0, 0, 0);
        // Down from 0 in wrap mode, then hold with ce low
        add(1, 0, 0, 0, 1, 9, MW, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 9, MW, 9, 1, 0, 0);
        add(0, 0, 0, 1, 0, 9, MW, 8, 0, 0, 0);
        add(0, 0, 0, 1, 0, 9, MW, 7, 0, 0, 0);
        for (int k = 0; k < 3; k++)
            add(0, 0, 0, 0, 0, 9, MW, 7, 0, 0, 0);
        // Saturate mode, M=5
        add(0, 1, 3, 0, 1, 5, MS, 3, 0, 0, 0);
        add(0, 0, 0, 1, 1, 5, MS, 4, 0, 0, 0);
        for (int k = 0; k < 3; k++)
            add(0, 0, 0, 1, 1, 5, MS, 5, 0, 0, 1);
        add(0, 0, 0, 1, 0, 5, MS, 4, 0, 0, 0);
        // One-shot mode, M=3
        add(1, 0, 0, 0, 1, 3, MO, 0, 0, 0, 0);
        add(0, 0, 0, 1, 1, 3, MO, 1, 0, 0, 0);
        add(0, 0, 0, 1, 1, 3, MO, 2, 0, 0, 0);
        add(0, 0, 0, 1, 1, 3, MO, 3, 0, 0, 1);
        add(0, 0, 0, 1, 1, 3, MO, 3, 0, 1, 0);
        add(0, 0, 0, 1, 1, 3, MO, 3, 0, 1, 0);
        add(0, 0, 0, 1, 1, 3, MO, 3, 0, 1, 0);
        add(0, 1, 1, 1, 1, 3, MO, 1, 0, 0, 0);
        add(0, 0, 0, 1, 1, 3, MO, 2, 0, 0, 0);
        add(0, 0, 0, 1, 1, 3, MO, 3, 0, 0, 1);
        add(0, 0, 0, 1, 1, 3, MO, 3, 0, 1, 0);
        add(0, 0, 0, 0, 1, 3, MW, 3, 0, 0, 0);   // leaving one-shot drops done
        // Limit cases
        add(0, 1, 200, 0, 1, 50, MW, 50, 0, 0, 0);
        add(0, 1, 40,  0, 1, 50, MW, 40, 0, 0, 0);
        add(0, 0, 0,   1, 1, 10, MW, 10, 0, 0, 1);
        add(1, 1, 5,   1, 1, 10, MW, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++)
            add(0, 0, 0, 1, 1, 0, MW, 0, 1, 0, 1);
        add(0, 0, 0, 1, 0, 0, MW, 0, 1, 0, 1);
        add(0, 0, 0, 1, 1, 0, MO, 0, 0, 1, 0);
        add(0, 0, 0, 1, 0, 5, MS, 0, 0, 0, 1);
        add(0, 1, 254, 0, 1, 255, MW, 254, 0, 0, 0);
        add(0, 0, 0,   1, 1, 255, MW, 255, 0, 0, 1);
        add(0, 0, 0,   1, 1, 255, MW, 0, 1, 0, 0);

        // Power-on reset
        rst = 1'b1; clr = 1'b0; ld = 1'b0; ld_val = 8'd0; ce = 1'b0;
        ctr = 1'b1; mod = 8'd9; mode = MW;
        #12;
        check_all("reset", 0, 0, 0, 0);
        $display("reset: d_out=%0d wrap=%0b done=%0b tc=%0b", d_out, wrap_o, done_o, tc_o);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            clr = vq[i].clr; ld = vq[i].ld; ld_val = vq[i].ld_val; ce = vq[i].ce;
            ctr = vq[i].ctr; mod = vq[i].mod; mode = vq[i].mode;
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vq[i].e_d, vq[i].e_wrap, vq[i].e_done, vq[i].e_tc);
            $display("vec%0d: clr=%0b ld=%0b ce=%0b up=%0b mod=%0d mode=%0d -> d=%0d wrap=%0b done=%0b tc=%0b",
                     i, clr, ld, ce, ctr, mod, mode, d_out, wrap_o, done_o, tc_o);
        end

        // Asynchronous reset in the middle of a cycle at d_out = 7
        @(negedge clk);
        clr = 1'b1; ld = 1'b0; ce = 1'b0; ctr = 1'b1; mod = 8'd9; mode = MW;
        @(negedge clk);
        clr = 1'b0; ce = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        check("arst.pre_d", d_out, 8'd7);
        #2;
        rst = 1'b1;
        #1;
        check("arst.d_out", d_out, 8'd0);
        check("arst.wrap_o", {7'd0, wrap_o}, 8'd0);
        check("arst.done_o", {7'd0, done_o}, 8'd0);
        $display("arst at 7: d_out=%0d wrap=%0b done=%0b", d_out, wrap_o, done_o);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("arst.restart", d_out, 8'd1);
        $display("after release: d_out=%0d", d_out);

        // Asynchronous reset clears a finished one-shot
        @(negedge clk);
        mode = MO; mod = 8'd1;
        @(posedge clk);
        #1;
        check("os.done_set", {7'd0, done_o}, 8'd1);
        #2;
        rst = 1'b1;
        #1;
        check("os.arst_done", {7'd0, done_o}, 8'd0);
        check("os.arst_d", d_out, 8'd0);
        $display("one-shot arst: d_out=%0d done=%0b", d_out, done_o);
        @(negedge clk);
        rst = 1'b0; ce = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
